// File: rtl/run_ctrl.sv
// Run/step/halt controller producing the CPU clock enable and a retired-instruction count.
// Define RUN_CTRL_BREAKPOINT_EN to build in the breakpoint compare; otherwise bp_addr/bp_valid are ignored.
module run_ctrl #(
   parameter logic [31:0] HALT_INSTR = 32'hD4400000,
   parameter int          CNT_W      = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             run_req,
   input  logic             step_req,
   input  logic             halt_req,
   input  logic [63:0]      pc,
   input  logic [31:0]      instr,
   input  logic [63:0]      bp_addr,
   input  logic             bp_valid,
   output logic             cpu_en,
   output logic [1:0]       state,
   output logic [1:0]       halt_cause,
   output logic [CNT_W-1:0] retired
);

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_RUN  = 2'b01,
      S_STEP = 2'b10,
      S_HALT = 2'b11
   } state_t;

   localparam logic [1:0] C_NONE = 2'b00;
   localparam logic [1:0] C_HREQ = 2'b01;
   localparam logic [1:0] C_BP   = 2'b10;
   localparam logic [1:0] C_HINS = 2'b11;

   state_t           r_state;
   state_t           w_state_next;
   logic [1:0]       r_cause;
   logic [1:0]       w_cause_next;
   logic             r_first;
   logic             w_first_next;
   logic             r_run_q;
   logic             r_step_q;
   logic             r_halt_q;
   logic             w_halt_ev;
   logic             w_step_ev;
   logic             w_run_ev;
   logic             w_is_halt_instr;
   logic             w_bp_hit;
   logic             w_en;
   logic [CNT_W-1:0] r_retired;

   // Edge registers reset to 1 so a request held through reset is not seen as new.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_run_q  <= 1'b1;
         r_step_q <= 1'b1;
         r_halt_q <= 1'b1;
      end else begin
         r_run_q  <= run_req;
         r_step_q <= step_req;
         r_halt_q <= halt_req;
      end
   end

   assign w_halt_ev       = halt_req & ~r_halt_q;
   assign w_step_ev       = step_req & ~r_step_q & ~w_halt_ev;
   assign w_run_ev        = run_req & ~r_run_q & ~w_halt_ev & ~w_step_ev;
   assign w_is_halt_instr = (instr == HALT_INSTR);

`ifdef RUN_CTRL_BREAKPOINT_EN
   // Suppressed on the first RUN cycle so a resume from a breakpoint can leave it.
   assign w_bp_hit = bp_valid && (pc == bp_addr) && !r_first;
`else
   logic w_unused_bp;
   assign w_unused_bp = ^{pc, bp_addr, bp_valid, r_first};
   assign w_bp_hit    = 1'b0;
`endif

   always_comb begin
      w_state_next = r_state;
      w_cause_next = r_cause;
      w_en         = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_step_ev) begin
               w_state_next = S_STEP;
            end else if (w_run_ev) begin
               w_state_next = S_RUN;
            end
         end
         S_RUN: begin
            if (w_is_halt_instr) begin
               w_state_next = S_HALT;
               w_cause_next = C_HINS;
            end else if (w_bp_hit) begin
               w_state_next = S_HALT;
               w_cause_next = C_BP;
            end else if (w_halt_ev) begin
               w_state_next = S_HALT;
               w_cause_next = C_HREQ;
            end else begin
               w_en = 1'b1;
            end
         end
         S_STEP: begin
            w_state_next = S_HALT;
            if (w_is_halt_instr) begin
               w_cause_next = C_HINS;
            end else if (w_halt_ev) begin
               w_cause_next = C_HREQ;
            end else begin
               w_cause_next = C_NONE;
               w_en         = 1'b1;
            end
         end
         S_HALT: begin
            if (w_step_ev) begin
               w_state_next = S_STEP;
               w_cause_next = C_NONE;
            end else if (w_run_ev) begin
               // Resuming onto a halt instruction would stop at once; stay halted.
               if (w_is_halt_instr) begin
                  w_cause_next = C_HINS;
               end else begin
                  w_state_next = S_RUN;
                  w_cause_next = C_NONE;
               end
            end
         end
         default: begin
            w_state_next = S_IDLE;
            w_cause_next = C_NONE;
         end
      endcase
      w_first_next = (w_state_next == S_RUN) && (r_state != S_RUN);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_cause <= C_NONE;
         r_first <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_cause <= w_cause_next;
         r_first <= w_first_next;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_retired <= '0;
      end else if (cpu_en && (r_retired != {CNT_W{1'b1}})) begin
         r_retired <= r_retired + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   assign cpu_en     = w_en & ~rst;
   assign state      = r_state;
   assign halt_cause = r_cause;
   assign retired    = r_retired;

endmodule

// File: tb/tb_run_ctrl.sv
// Directed bench for run_ctrl: a 32-bit counter instance and a 4-bit counter instance share stimulus.
module tb_run_ctrl;

   localparam logic [31:0] HALT_W = 32'hD4400000;

   logic        clk = 1'b0;
   logic        rst;
   logic        run_req;
   logic        step_req;
   logic        halt_req;
   logic [63:0] pc;
   logic [31:0] instr;
   logic [63:0] bp_addr;
   logic        bp_valid;
   logic        cpu_en;
   logic        cpu_en4;
   logic [1:0]  state;
   logic [1:0]  state4;
   logic [1:0]  cause;
   logic [1:0]  cause4;
   logic [31:0] retired;
   logic [3:0]  retired4;

   int n_pass  = 0;
   int n_total = 0;
   int exp_ret = 0;

   always #5 clk = ~clk;

   run_ctrl #(.HALT_INSTR(HALT_W), .CNT_W(32)) u_dut (
      .clk(clk), .rst(rst), .run_req(run_req), .step_req(step_req), .halt_req(halt_req),
      .pc(pc), .instr(instr), .bp_addr(bp_addr), .bp_valid(bp_valid),
      .cpu_en(cpu_en), .state(state), .halt_cause(cause), .retired(retired)
   );

   run_ctrl #(.HALT_INSTR(HALT_W), .CNT_W(4)) u_dut4 (
      .clk(clk), .rst(rst), .run_req(run_req), .step_req(step_req), .halt_req(halt_req),
      .pc(pc), .instr(instr), .bp_addr(bp_addr), .bp_valid(bp_valid),
      .cpu_en(cpu_en4), .state(state4), .halt_cause(cause4), .retired(retired4)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
         $error("check %s did not match", tag);
      end
   endtask

   initial begin
      rst = 1'b1; run_req = 1'b0; step_req = 1'b0; halt_req = 1'b0;
      pc = 64'h0; instr = 32'h0; bp_addr = 64'h40; bp_valid = 1'b0;
      tick(); tick();
      chk("rst_cpu_en", {63'd0, cpu_en}, 64'd0);
      chk("rst_state", {62'd0, state}, 64'd0);
      chk("rst_cause", {62'd0, cause}, 64'd0);
      chk("rst_retired", {32'd0, retired}, 64'd0);
      chk("rst_retired4", {60'd0, retired4}, 64'd0);
      rst = 1'b0;
      tick();

      // free run for 10 cycles
      run_req = 1'b1; #1;
      chk("idle_cpu_en", {63'd0, cpu_en}, 64'd0);
      chk("idle_state", {62'd0, state}, 64'd0);
      tick();
      run_req = 1'b0;
      for (int i = 0; i < 10; i++) begin
         pc = 64'(i * 4); #1;
         chk("run_cpu_en", {63'd0, cpu_en}, 64'd1);
         tick();
         exp_ret++;
      end
      chk("run_state", {62'd0, state}, 64'd1);
      chk("run_retired", {32'd0, retired}, 64'd10);
      chk("run_retired4", {60'd0, retired4}, 64'd10);

      // halt and run rising together: halt wins
      halt_req = 1'b1; run_req = 1'b1; #1;
      chk("hreq_cpu_en", {63'd0, cpu_en}, 64'd0);
      tick();
      halt_req = 1'b0; run_req = 1'b0; #1;
      chk("hreq_state", {62'd0, state}, 64'd3);
      chk("hreq_cause", {62'd0, cause}, 64'd1);
      chk("hreq_retired", {32'd0, retired}, 64'(exp_ret));

      // single step from HALT
      step_req = 1'b1; #1;
      chk("halt_cpu_en", {63'd0, cpu_en}, 64'd0);
      tick();
      step_req = 1'b0; #1;
      chk("step_state", {62'd0, state}, 64'd2);
      chk("step_cause_clr", {62'd0, cause}, 64'd0);
      chk("step_cpu_en", {63'd0, cpu_en}, 64'd1);
      tick();
      exp_ret++; #1;
      chk("step_done_state", {62'd0, state}, 64'd3);
      chk("step_done_cause", {62'd0, cause}, 64'd0);
      chk("step_done_cpu_en", {63'd0, cpu_en}, 64'd0);
      chk("step_retired", {32'd0, retired}, 64'(exp_ret));
      tick();
      chk("step_once", {32'd0, retired}, 64'(exp_ret));

      // step and run rising together: step wins
      step_req = 1'b1; run_req = 1'b1;
      tick();
      step_req = 1'b0; run_req = 1'b0; #1;
      chk("prio_step_state", {62'd0, state}, 64'd2);
      tick();
      exp_ret++; #1;
      chk("prio_step_halt", {62'd0, state}, 64'd3);

      // breakpoint at 0x40
      bp_valid = 1'b1; pc = 64'h30; run_req = 1'b1;
      tick();
      run_req = 1'b0; pc = 64'h38; #1;
      chk("bp_pre_cpu_en", {63'd0, cpu_en}, 64'd1);
      chk("bp_pre_state", {62'd0, state}, 64'd1);
      tick();
      exp_ret++;
      pc = 64'h40; #1;
`ifdef RUN_CTRL_BREAKPOINT_EN
      chk("bp_hit_cpu_en", {63'd0, cpu_en}, 64'd0);
      tick(); #1;
      chk("bp_hit_state", {62'd0, state}, 64'd3);
      chk("bp_hit_cause", {62'd0, cause}, 64'd2);
`else
      chk("bp_off_cpu_en", {63'd0, cpu_en}, 64'd1);
      tick();
      exp_ret++;
      chk("bp_off_state", {62'd0, state}, 64'd1);
      halt_req = 1'b1; #1;
      chk("bp_off_hreq_en", {63'd0, cpu_en}, 64'd0);
      tick();
      halt_req = 1'b0; #1;
      chk("bp_off_hstate", {62'd0, state}, 64'd3);
      chk("bp_off_hcause", {62'd0, cause}, 64'd1);
`endif
      run_req = 1'b1;
      tick();
      run_req = 1'b0; #1;
      chk("bp_resume_state", {62'd0, state}, 64'd1);
      chk("bp_resume_cpu_en", {63'd0, cpu_en}, 64'd1);
      chk("bp_resume_cause", {62'd0, cause}, 64'd0);
      tick();
      exp_ret++;
      pc = 64'h44; halt_req = 1'b1; #1;
      chk("bp_stop_cpu_en", {63'd0, cpu_en}, 64'd0);
      tick();
      halt_req = 1'b0; #1;
      chk("bp_stop_state", {62'd0, state}, 64'd3);
      chk("bp_stop_retired", {32'd0, retired}, 64'(exp_ret));

      // halt instruction, then resume onto it
      bp_valid = 1'b0; pc = 64'h100; run_req = 1'b1;
      tick();
      run_req = 1'b0; #1;
      chk("hins_pre_cpu_en", {63'd0, cpu_en}, 64'd1);
      tick();
      exp_ret++;
      instr = HALT_W; #1;
      chk("hins_cpu_en", {63'd0, cpu_en}, 64'd0);
      tick(); #1;
      chk("hins_state", {62'd0, state}, 64'd3);
      chk("hins_cause", {62'd0, cause}, 64'd3);
      chk("hins_retired", {32'd0, retired}, 64'(exp_ret));
      run_req = 1'b1; #1;
      chk("rehalt_cpu_en0", {63'd0, cpu_en}, 64'd0);
      tick();
      run_req = 1'b0; #1;
      chk("rehalt_cpu_en1", {63'd0, cpu_en}, 64'd0);
      chk("rehalt_state", {62'd0, state}, 64'd3);
      chk("rehalt_cause", {62'd0, cause}, 64'd3);
      tick();
      chk("rehalt_retired", {32'd0, retired}, 64'(exp_ret));
      chk("rehalt_state2", {62'd0, state}, 64'd3);
      instr = 32'h0;

      // run_req held high through reset
      run_req = 1'b1; rst = 1'b1;
      tick(); tick();
      chk("rst2_state", {62'd0, state}, 64'd0);
      chk("rst2_cause", {62'd0, cause}, 64'd0);
      chk("rst2_retired", {32'd0, retired}, 64'd0);
      chk("rst2_retired4", {60'd0, retired4}, 64'd0);
      rst = 1'b0;
      tick(); tick(); #1;
      chk("held_state", {62'd0, state}, 64'd0);
      chk("held_cpu_en", {63'd0, cpu_en}, 64'd0);
      run_req = 1'b0;
      tick();
      run_req = 1'b1;
      tick();
      run_req = 1'b0; #1;
      chk("toggle_state", {62'd0, state}, 64'd1);
      chk("toggle_cpu_en", {63'd0, cpu_en}, 64'd1);

      // 20 enabled cycles: 4-bit counter saturates at 15
      for (int i = 0; i < 20; i++) begin
         tick();
         if (i == 14) chk("sat_reach4", {60'd0, retired4}, 64'hF);
      end
      chk("sat_hold4", {60'd0, retired4}, 64'hF);
      chk("sat_retired32", {32'd0, retired}, 64'd20);
      chk("sat_state", {62'd0, state}, 64'd1);

      // reset during RUN aborts in the same cycle
      rst = 1'b1; #1;
      chk("rst_abort_cpu_en", {63'd0, cpu_en}, 64'd0);
      tick();
      rst = 1'b0; #1;
      chk("rst_abort_state", {62'd0, state}, 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
